// File: rtl/mac_scheduler_pkg.sv
// Shared DSP package: scheduler state encoding and
// sizing constants for the multi-rate MAC scheduler.
package mac_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  localparam int NSTG  = 3;
  localparam int TAP_W = 8;

endpackage

// File: rtl/mac_scheduler.sv
// Time-shares one MAC across three half-band stages:
// queues one request per stage, serves lowest stage first.
module mac_scheduler
  import mac_scheduler_pkg::*;
#(
  parameter int TAPS0 = 64,
  parameter int TAPS1 = 32,
  parameter int TAPS2 = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sched_en,
  input  logic [NSTG-1:0]  stg_trig,
  input  logic             ovf_clr,
  output logic             mac_en,
  output logic             mac_clr,
  output logic [1:0]       mac_sel,
  output logic [TAP_W-1:0] tap_idx,
  output logic [NSTG-1:0]  stg_done,
  output logic [NSTG-1:0]  ovf,
  output logic             busy
);

  if (TAPS0 < 1 || TAPS0 > 256) begin : g_chk0
    $error("TAPS0 must be within 1..256");
  end
  if (TAPS1 < 1 || TAPS1 > 256) begin : g_chk1
    $error("TAPS1 must be within 1..256");
  end
  if (TAPS2 < 1 || TAPS2 > 256) begin : g_chk2
    $error("TAPS2 must be within 1..256");
  end

  localparam logic [TAP_W-1:0] LAST0 = TAP_W'(TAPS0 - 1);
  localparam logic [TAP_W-1:0] LAST1 = TAP_W'(TAPS1 - 1);
  localparam logic [TAP_W-1:0] LAST2 = TAP_W'(TAPS2 - 1);

  // Fixed priority: stage 0 (lowest rate, longest job) wins.
  function automatic logic [1:0] pick(
    input logic [NSTG-1:0] p
  );
    if (p[0])      return 2'd0;
    else if (p[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  function automatic logic [TAP_W-1:0] last_tap(
    input logic [1:0] s
  );
    case (s)
      2'd0:    return LAST0;
      2'd1:    return LAST1;
      default: return LAST2;
    endcase
  endfunction

  sched_state_e     state_q, state_d;
  logic [NSTG-1:0]  pend_q, pend_d;
  logic [NSTG-1:0]  ovf_q, ovf_d;
  logic [1:0]       sel_q, sel_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [NSTG-1:0]  clr_mask;
  logic [NSTG-1:0]  trig_v;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    tap_d    = tap_q;
    clr_mask = '0;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          sel_d    = pick(pend_q);
          clr_mask = 3'b001 << pick(pend_q);
          tap_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (tap_q == last_tap(sel_q)) begin
          state_d = DONE;
        end else begin
          tap_d = tap_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A set in the select cycle re-queues the stage; only a
  // trigger against a still-queued request counts as lost.
  always_comb begin
    trig_v = stg_trig & {NSTG{sched_en}};
    pend_d = (pend_q & ~clr_mask) | trig_v;
    ovf_d  = (ovf_clr ? '0 : ovf_q)
           | (trig_v & pend_q & ~clr_mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ovf_q   <= '0;
      sel_q   <= '0;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      sel_q   <= sel_d;
      tap_q   <= tap_d;
    end
  end

  always_comb begin
    mac_en   = (state_q == RUN);
    mac_clr  = (state_q == RUN) && (tap_q == '0);
    busy     = (state_q != IDLE);
    stg_done = (state_q == DONE) ? (3'b001 << sel_q) : '0;
    mac_sel  = sel_q;
    tap_idx  = tap_q;
    ovf      = ovf_q;
  end

endmodule

// File: tb/tb_mac_scheduler.sv
// Scoreboard bench for mac_scheduler: directed triggers,
// expected stg_done pulses queued and matched by a monitor.
module tb_mac_scheduler;

  logic       clk;
  logic       rst_n;
  logic       sched_en;
  logic [2:0] stg_trig;
  logic       ovf_clr;
  logic       mac_en, mac_clr, busy;
  logic [1:0] mac_sel;
  logic [7:0] tap_idx;
  logic [2:0] stg_done, ovf;

  logic [2:0] b_trig;
  logic       b_en, b_clr, b_busy;
  logic [1:0] b_sel;
  logic [7:0] b_tap;
  logic [2:0] b_done, b_ovf;

  mac_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
    .stg_trig(stg_trig), .ovf_clr(ovf_clr),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_sel(mac_sel),
    .tap_idx(tap_idx), .stg_done(stg_done), .ovf(ovf),
    .busy(busy)
  );

  mac_scheduler #(.TAPS0(1), .TAPS1(32), .TAPS2(256)) u_edge (
    .clk(clk), .rst_n(rst_n), .sched_en(1'b1),
    .stg_trig(b_trig), .ovf_clr(1'b0),
    .mac_en(b_en), .mac_clr(b_clr), .mac_sel(b_sel),
    .tap_idx(b_tap), .stg_done(b_done), .ovf(b_ovf),
    .busy(b_busy)
  );

  typedef struct {
    logic [2:0] stg;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   c;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (stg_done !== 3'b000) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected got %b at cycle %0d expected none",
                 stg_done, cyc);
      end else begin
        e = sb.pop_front();
        if (stg_done !== e.stg || cyc != e.at) begin
          errors++;
          $display("FAIL done_match got %b at %0d expected %b at %0d",
                   stg_done, cyc, e.stg, e.at);
        end
      end
    end
  end

  task automatic at(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] s, input int t);
    exp_t e;
    e.stg = s;
    e.at  = t;
    sb.push_back(e);
  endtask

  initial begin
    rst_n    = 1'b0;
    sched_en = 1'b1;
    stg_trig = '0;
    ovf_clr  = 1'b0;
    b_trig   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mac_en", 32'(mac_en), 0);
    chk("rst_mac_clr", 32'(mac_clr), 0);
    chk("rst_tap", 32'(tap_idx), 0);
    chk("rst_sel", 32'(mac_sel), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_done", 32'(stg_done), 0);
    rst_n = 1'b1;
    at(cyc + 2);

    // single stage-2 job
    c = cyc;
    push(3'b100, c + 18);
    stg_trig = 3'b100;
    at(c + 1);
    stg_trig = '0;
    chk("sel_cycle_busy", 32'(busy), 0);
    at(c + 2);
    chk("job_busy", 32'(busy), 1);
    chk("job_sel", 32'(mac_sel), 2);
    for (int i = 0; i < 16; i++) begin
      at(c + 2 + i);
      chk("run_en", 32'(mac_en), 1);
      chk("run_tap", 32'(tap_idx), 32'(i));
      chk("run_clr", 32'(mac_clr), (i == 0) ? 1 : 0);
    end
    at(c + 18);
    chk("done_en", 32'(mac_en), 0);
    chk("done_busy", 32'(busy), 1);
    at(c + 19);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_tap_hold", 32'(tap_idx), 15);

    // all three at once: 0, then 1, then 2
    at(c + 22);
    c = cyc;
    push(3'b001, c + 66);
    push(3'b010, c + 100);
    push(3'b100, c + 118);
    stg_trig = 3'b111;
    at(c + 1);
    stg_trig = '0;
    at(c + 125);
    chk("all3_ovf", 32'(ovf), 0);

    // overflow on stage 1 while stage 0 runs
    c = cyc;
    push(3'b001, c + 66);
    push(3'b010, c + 100);
    stg_trig = 3'b001;
    at(c + 1);  stg_trig = '0;
    at(c + 10); stg_trig = 3'b010;
    at(c + 11); stg_trig = '0;
    at(c + 20); stg_trig = 3'b010;
    at(c + 21); stg_trig = '0;
    at(c + 30);
    chk("ovf_set", 32'(ovf), 32'h2);
    at(c + 105);
    chk("ovf_sticky", 32'(ovf), 32'h2);
    ovf_clr = 1'b1;
    at(c + 106);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 0);

    // retrigger in the select cycle re-queues without ovf
    at(c + 110);
    c = cyc;
    push(3'b100, c + 18);
    push(3'b100, c + 36);
    stg_trig = 3'b100;
    at(c + 2);
    stg_trig = '0;
    at(c + 40);
    chk("setwin_ovf", 32'(ovf), 0);

    // ovf_clr coincident with a new overflow
    c = cyc;
    push(3'b001, c + 66);
    push(3'b010, c + 100);
    push(3'b100, c + 118);
    stg_trig = 3'b001;
    at(c + 1); stg_trig = '0;
    at(c + 5); stg_trig = 3'b100;
    at(c + 6); stg_trig = 3'b010;
    at(c + 8); stg_trig = '0;
    at(c + 9);
    chk("ovf1_before_clr", 32'(ovf), 32'h2);
    at(c + 10);
    stg_trig = 3'b100;
    ovf_clr  = 1'b1;
    at(c + 11);
    stg_trig = '0;
    ovf_clr  = 1'b0;
    chk("ovf_clr_setwins", 32'(ovf), 32'h4);
    at(c + 125);
    ovf_clr = 1'b1;
    at(c + 126);
    ovf_clr = 1'b0;

    // sched_en low: queued jobs finish, new trigger ignored
    at(c + 130);
    c = cyc;
    push(3'b001, c + 66);
    push(3'b100, c + 84);
    stg_trig = 3'b001;
    at(c + 1);  stg_trig = '0;
    at(c + 3);  stg_trig = 3'b100;
    at(c + 4);  stg_trig = '0;
    at(c + 5);  sched_en = 1'b0;
    at(c + 10); stg_trig = 3'b010;
    at(c + 11); stg_trig = '0;
    at(c + 12); sched_en = 1'b1;
    at(c + 90);
    chk("en_ovf", 32'(ovf), 0);
    chk("en_idle", 32'(busy), 0);

    // reset mid-job at tap 20, trigger during reset dropped
    c = cyc;
    stg_trig = 3'b001;
    at(c + 1); stg_trig = '0;
    at(c + 22);
    chk("pre_rst_tap", 32'(tap_idx), 20);
    rst_n    = 1'b0;
    stg_trig = 3'b010;
    at(c + 23);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_en", 32'(mac_en), 0);
    chk("mid_rst_clr", 32'(mac_clr), 0);
    chk("mid_rst_tap", 32'(tap_idx), 0);
    chk("mid_rst_sel", 32'(mac_sel), 0);
    chk("mid_rst_ovf", 32'(ovf), 0);
    rst_n    = 1'b1;
    stg_trig = '0;
    at(c + 90);
    chk("post_rst_idle", 32'(busy), 0);
    c = cyc;
    push(3'b001, c + 66);
    stg_trig = 3'b001;
    at(c + 1); stg_trig = '0;
    at(c + 70);

    // one-tap and 256-tap stages on the second instance
    c = cyc;
    b_trig = 3'b001;
    at(c + 1); b_trig = '0;
    at(c + 2);
    chk("t1_en", 32'(b_en), 1);
    chk("t1_clr", 32'(b_clr), 1);
    chk("t1_tap", 32'(b_tap), 0);
    at(c + 3);
    chk("t1_done", 32'(b_done), 32'h1);
    chk("t1_done_en", 32'(b_en), 0);
    at(c + 4); b_trig = 3'b100;
    at(c + 5); b_trig = '0;
    at(c + 261);
    chk("t256_last_tap", 32'(b_tap), 255);
    chk("t256_last_en", 32'(b_en), 1);
    chk("t256_no_done", 32'(b_done), 0);
    at(c + 262);
    chk("t256_done", 32'(b_done), 32'h4);
    chk("t256_ovf", 32'(b_ovf), 0);

    at(cyc + 3);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
